// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: forwards controller lights to the lamps and latches conflicts, bad codes,
// short yellow or a stalled controller into a flashing fail-safe pattern until cleared.
module traffic_conflict_monitor #(
    parameter int GLITCH_CYC   = 1,
    parameter int MIN_YELLOW   = 3,
    parameter int WATCHDOG_CYC = 120,
    parameter int FLASH_HALF   = 1,
    parameter int ARM_CYC      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_MT,
    input  logic [2:0] light_S,
    input  logic       fault_clr,
    output logic [2:0] lamp_M1,
    output logic [2:0] lamp_M2,
    output logic [2:0] lamp_MT,
    output logic [2:0] lamp_S,
    output logic       fault,
    output logic [3:0] fault_code
);
    localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001, DARK = 3'b000;
    localparam int GW = $clog2(GLITCH_CYC + 2);
    localparam int YW = $clog2(MIN_YELLOW + 2);
    localparam int WW = $clog2(WATCHDOG_CYC + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);
    localparam int AW = $clog2(ARM_CYC + 1);
    localparam logic [GW-1:0] G_LIM = GW'(GLITCH_CYC);
    localparam logic [YW-1:0] Y_LIM = YW'(MIN_YELLOW);
    localparam logic [WW-1:0] W_LIM = WW'(WATCHDOG_CYC - 1);
    localparam logic [FW-1:0] F_LIM = FW'(FLASH_HALF - 1);
    localparam logic [AW-1:0] A_LIM = AW'(ARM_CYC - 1);

    typedef enum logic [1:0] {ARMING, MONITOR, FAULT} state_t;

    state_t state;
    logic [2:0] light [4];
    logic [2:0] lamp [4];
    logic [2:0] last_valid [4];
    logic [2:0] prev [4];
    logic [YW-1:0] yel_cnt [4];
    logic [GW-1:0] conf_cnt, inv_cnt;
    logic [WW-1:0] wd_cnt;
    logic [FW-1:0] flash_cnt;
    logic [AW-1:0] arm_cnt;
    logic flash_on, flash_nxt, conflict, invalid, changed, all_red;
    logic [3:0] valid, perm, yel_bad, hit;

    assign light   = '{light_M1, light_M2, light_MT, light_S};
    assign lamp_M1 = lamp[0];
    assign lamp_M2 = lamp[1];
    assign lamp_MT = lamp[2];
    assign lamp_S  = lamp[3];
    assign changed = {light[0], light[1], light[2], light[3]} != {prev[0], prev[1], prev[2], prev[3]};
    assign all_red = {light[0], light[1], light[2], light[3]} == {RED, RED, RED, RED};

    always_comb begin
        valid   = '0;
        perm    = '0;
        yel_bad = '0;
        for (int i = 0; i < 4; i++) begin
            valid[i]   = $onehot(light[i]);
            perm[i]    = light[i] == YEL || light[i] == GRN;
            yel_bad[i] = valid[i] && light[i] == RED &&
                         (last_valid[i] == GRN || (last_valid[i] == YEL && yel_cnt[i] < Y_LIM));
        end
        conflict  = (perm[3] && (perm[0] || perm[1] || perm[2])) || (perm[2] && perm[1]);
        invalid   = ~&valid;
        hit       = {!changed && wd_cnt == W_LIM, |yel_bad, invalid && inv_cnt == G_LIM,
                     conflict && conf_cnt == G_LIM};
        flash_nxt = flash_cnt == F_LIM ? ~flash_on : flash_on;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARMING;
            fault      <= 1'b0;
            fault_code <= '0;
            conf_cnt   <= '0;
            inv_cnt    <= '0;
            wd_cnt     <= '0;
            flash_cnt  <= '0;
            arm_cnt    <= '0;
            flash_on   <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                lamp[i]       <= RED;
                last_valid[i] <= RED;
                prev[i]       <= RED;
                yel_cnt[i]    <= '0;
            end
        end else begin
            case (state)
                ARMING: begin
                    arm_cnt  <= arm_cnt == A_LIM ? '0 : arm_cnt + 1'b1;
                    state    <= arm_cnt == A_LIM ? MONITOR : ARMING;
                    conf_cnt <= '0;
                    inv_cnt  <= '0;
                    wd_cnt   <= '0;
                    for (int i = 0; i < 4; i++) begin
                        lamp[i]       <= RED;
                        prev[i]       <= light[i];
                        last_valid[i] <= valid[i] ? light[i] : last_valid[i];
                        // a yellow already showing at entry is treated as fully timed
                        yel_cnt[i]    <= light[i] == YEL ? Y_LIM : '0;
                    end
                end
                MONITOR: begin
                    conf_cnt <= !conflict ? '0 : conf_cnt == G_LIM ? conf_cnt : conf_cnt + 1'b1;
                    inv_cnt  <= !invalid ? '0 : inv_cnt == G_LIM ? inv_cnt : inv_cnt + 1'b1;
                    wd_cnt   <= changed ? '0 : wd_cnt == W_LIM ? wd_cnt : wd_cnt + 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        prev[i]       <= light[i];
                        last_valid[i] <= valid[i] ? light[i] : last_valid[i];
                        yel_cnt[i]    <= !valid[i] ? yel_cnt[i] : light[i] != YEL ? '0 :
                                         yel_cnt[i] == Y_LIM ? yel_cnt[i] : yel_cnt[i] + 1'b1;
                        lamp[i]       <= !(|hit) ? light[i] : i < 2 ? YEL : RED;
                    end
                    if (|hit) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= fault_code | hit;
                        flash_on   <= 1'b1;
                        flash_cnt  <= '0;
                    end
                end
                default: begin
                    flash_cnt <= flash_cnt == F_LIM ? '0 : flash_cnt + 1'b1;
                    flash_on  <= flash_nxt;
                    for (int i = 0; i < 4; i++)
                        lamp[i] <= !flash_nxt ? DARK : i < 2 ? YEL : RED;
                    // clearing is only safe once the controller itself shows all red
                    if (fault_clr && all_red) begin
                        state      <= ARMING;
                        fault      <= 1'b0;
                        fault_code <= '0;
                        arm_cnt    <= '0;
                        flash_cnt  <= '0;
                        flash_on   <= 1'b1;
                        for (int i = 0; i < 4; i++)
                            lamp[i] <= RED;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb_traffic_conflict_monitor: directed vector table plus hand sequences for async reset and watchdog.
module tb_traffic_conflict_monitor;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, D = 3'b000, X = 3'b011;
    localparam logic [11:0] ALLR = {R, R, R, R};
    localparam logic [11:0] FON = {Y, Y, R, R};
    localparam logic [11:0] FOFF = {D, D, D, D};
    localparam logic [4:0] OK = 5'b0_0000, F1 = 5'b1_0001, F3 = 5'b1_0011, F4 = 5'b1_0100;

    typedef struct {
        logic [11:0] li;
        logic        clr;
        logic [16:0] exp;
    } vec_t;

    logic clk = 1'b0, reset = 1'b0, fault_clr = 1'b0;
    logic [2:0] light_M1 = R, light_M2 = R, light_MT = R, light_S = R;
    logic [2:0] lamp_M1, lamp_M2, lamp_MT, lamp_S;
    logic fault;
    logic [3:0] fault_code;
    logic [16:0] obs;
    vec_t vecs[$];
    int errors = 0, checks = 0, n;

    traffic_conflict_monitor dut (
        .clk(clk), .reset(reset),
        .light_M1(light_M1), .light_M2(light_M2), .light_MT(light_MT), .light_S(light_S),
        .fault_clr(fault_clr),
        .lamp_M1(lamp_M1), .lamp_M2(lamp_M2), .lamp_MT(lamp_MT), .lamp_S(lamp_S),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;
    assign obs = {lamp_M1, lamp_M2, lamp_MT, lamp_S, fault, fault_code};

    function automatic void addn(input int cnt, input logic [11:0] li, input logic clr, input logic [16:0] exp);
        vec_t v;
        v.li  = li;
        v.clr = clr;
        v.exp = exp;
        for (int k = 0; k < cnt; k++) vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [11:0] li, input logic clr);
        {light_M1, light_M2, light_MT, light_S} = li;
        fault_clr = clr;
    endtask

    initial begin
        addn(3, {G, G, R, R}, 0, {ALLR, OK});
        addn(2, {G, G, R, R}, 0, {G, G, R, R, OK});
        addn(3, {Y, Y, R, R}, 0, {Y, Y, R, R, OK});
        addn(1, ALLR, 0, {ALLR, OK});
        addn(2, {R, R, G, R}, 0, {R, R, G, R, OK});
        addn(3, {R, R, Y, R}, 0, {R, R, Y, R, OK});
        addn(1, ALLR, 0, {ALLR, OK});
        addn(2, {R, R, R, G}, 0, {R, R, R, G, OK});
        addn(3, {R, R, R, Y}, 0, {R, R, R, Y, OK});
        addn(1, ALLR, 0, {ALLR, OK});
        addn(3, {Y, R, R, R}, 0, {Y, R, R, R, OK});
        addn(1, {Y, R, R, G}, 0, {Y, R, R, G, OK});
        addn(1, {R, R, R, G}, 0, {R, R, R, G, OK});
        addn(3, {R, R, R, Y}, 0, {R, R, R, Y, OK});
        addn(1, ALLR, 0, {ALLR, OK});
        addn(1, {G, R, R, G}, 0, {G, R, R, G, OK});
        addn(1, {G, R, R, G}, 0, {FON, F1});
        addn(1, {G, R, R, G}, 0, {FOFF, F1});
        addn(1, {G, R, R, G}, 0, {FON, F1});
        addn(1, {G, R, R, G}, 0, {FOFF, F1});
        addn(1, {G, R, R, G}, 1, {FON, F1});
        addn(1, ALLR, 1, {ALLR, OK});
        addn(3, ALLR, 0, {ALLR, OK});
        addn(1, {G, G, R, R}, 0, {G, G, R, R, OK});
        addn(1, {G, G, R, R}, 1, {G, G, R, R, OK});
        addn(2, {G, Y, R, R}, 0, {G, Y, R, R, OK});
        addn(1, {G, R, R, R}, 0, {FON, F4});
        addn(1, {G, R, R, R}, 0, {FOFF, F4});
        addn(1, ALLR, 1, {ALLR, OK});
        addn(3, ALLR, 0, {ALLR, OK});
        addn(1, {R, R, G, R}, 0, {R, R, G, R, OK});
        addn(1, ALLR, 0, {FON, F4});
        addn(1, ALLR, 1, {ALLR, OK});
        addn(3, ALLR, 0, {ALLR, OK});
        addn(1, {R, G, G, X}, 0, {R, G, G, X, OK});
        addn(1, {R, G, G, X}, 0, {FON, F3});
        addn(1, ALLR, 1, {ALLR, OK});
        addn(3, ALLR, 0, {ALLR, OK});

        repeat (2) @(posedge clk);
        #1 chk("reset_state", 32'(obs), 32'({ALLR, OK}));
        reset = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].li, vecs[i].clr);
            @(posedge clk);
            #1 chk($sformatf("row%0d", i + 1), 32'(obs), 32'(vecs[i].exp));
        end

        drive({G, R, R, G}, 0);
        @(posedge clk);
        #1 chk("mid_conf_first", 32'(obs), 32'({G, R, R, G, OK}));
        @(posedge clk);
        #1 chk("mid_conf_fault", 32'(obs), 32'({FON, F1}));
        @(posedge clk);
        #1 chk("mid_flash_off", 32'(obs), 32'({FOFF, F1}));
        #3 reset = 1'b0;
        #1 chk("async_reset", 32'(obs), 32'({ALLR, OK}));
        drive(ALLR, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        n = 0;
        while (n < 300 && !fault) begin
            @(posedge clk);
            #1 n++;
        end
        chk("wd_edges", 32'(n), 32'd123);
        chk("wd_out", 32'(obs), 32'({FON, 5'b1_1000}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
